// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM with sticky illegal flag and retire count.
// Ports: clk, rst (sync active-high), op, funct, zero, mem_ready in; datapath
// controls (pc_en, iord, mem_write, mem_req, ir_write, reg_write, reg_dst,
// mem_to_reg, alu_src_a, alu_src_b, pc_src, alu_control), state, illegal,
// retired out. Define MULTICYCLE_JUMP_EN to compile in the jump path.
module multicycle_control (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        iord,
  output logic        mem_write,
  output logic        mem_req,
  output logic        ir_write,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  pc_src,
  output logic [2:0]  alu_control,
  output logic [3:0]  state,
  output logic        illegal,
  output logic [31:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTEXE   = 4'd6,
    S_ALUWB   = 4'd7,
    S_BEQ     = 4'd8,
    S_ADDIEXE = 4'd9,
    S_JUMP    = 4'd10
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RT   = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t      state_q, state_d;
  logic        illegal_q, illegal_d;
  logic        imm_q, imm_d;
  logic [31:0] retired_q, retired_d;
  logic        retire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      imm_q     <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      imm_q     <= imm_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d     = S_FETCH;
    illegal_d   = illegal_q;
    imm_d       = imm_q;
    retire      = 1'b0;
    pc_en       = 1'b0;
    iord        = 1'b0;
    mem_write   = 1'b0;
    mem_req     = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    pc_src      = 2'b00;
    alu_control = 3'b000;
    case (state_q)
      S_FETCH: begin
        mem_req     = 1'b1;
        alu_src_b   = 2'b01;
        alu_control = 3'b010;
        ir_write    = mem_ready;
        pc_en       = mem_ready;
        state_d     = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b   = 2'b11;
        alu_control = 3'b010;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RT:        state_d = S_RTEXE;
          OP_BEQ:       state_d = S_BEQ;
          OP_ADDI:      state_d = S_ADDIEXE;
`ifdef MULTICYCLE_JUMP_EN
          OP_J:         state_d = S_JUMP;
`endif
          default: begin
            illegal_d = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = 3'b010;
        state_d     = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        iord      = 1'b1;
        mem_write = 1'b1;
        retire    = mem_ready;
        state_d   = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_RTEXE: begin
        alu_src_a = 1'b1;
        imm_d     = 1'b0;
        state_d   = S_ALUWB;
        case (funct)
          6'b100000: alu_control = 3'b010;
          6'b100010: alu_control = 3'b110;
          6'b100100: alu_control = 3'b000;
          6'b100101: alu_control = 3'b001;
          6'b101010: alu_control = 3'b111;
          default: begin
            illegal_d = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        // addi writes rt, R-type writes rd
        reg_dst   = ~imm_q;
        retire    = 1'b1;
        imm_d     = 1'b0;
        state_d   = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a   = 1'b1;
        alu_control = 3'b110;
        pc_src      = 2'b01;
        pc_en       = zero;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_ADDIEXE: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = 3'b010;
        imm_d       = 1'b1;
        state_d     = S_ALUWB;
      end
`ifdef MULTICYCLE_JUMP_EN
      S_JUMP: begin
        pc_en   = 1'b1;
        pc_src  = 2'b10;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
`endif
      default: state_d = S_FETCH;
    endcase
    retired_d = retired_q + {31'd0, retire};
    // keep side-effecting strobes quiet while reset is held
    if (rst) begin
      pc_en     = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
      mem_req   = 1'b0;
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control.
// Hand-computed expectations, immediate assertions, one summary line.
module tb_multicycle_control;
  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        zero;
  logic        mem_ready;
  logic        pc_en, iord, mem_write, mem_req, ir_write;
  logic        reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0]  alu_src_b, pc_src;
  logic [2:0]  alu_control;
  logic [3:0]  state;
  logic        illegal;
  logic [31:0] retired;

  int checks = 0;
  int failures = 0;

  multicycle_control dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord),
    .mem_write(mem_write), .mem_req(mem_req), .ir_write(ir_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
    .alu_control(alu_control), .state(state), .illegal(illegal),
    .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    tick();
    tick();
    chk("rst_state", {28'd0, state}, 0);
    chk("rst_retired", retired, 0);
    chk("rst_illegal", {31'd0, illegal}, 0);
    chk("rst_mem_req", {31'd0, mem_req}, 0);
    mem_ready = 1'b1;
    #1;
    chk("rst_pc_en", {31'd0, pc_en}, 0);
    chk("rst_ir_write", {31'd0, ir_write}, 0);
    rst = 1'b0;
    #1;
    chk("fetch_mem_req", {31'd0, mem_req}, 1);
    chk("fetch_ir_write", {31'd0, ir_write}, 1);
    chk("fetch_alu_src_b", {30'd0, alu_src_b}, 1);

    // lw, memory always ready
    op = 6'b100011;
    tick();
    chk("lw_s1", {28'd0, state}, 1);
    chk("lw_dec_src_b", {30'd0, alu_src_b}, 3);
    chk("lw_dec_reg_write", {31'd0, reg_write}, 0);
    tick();
    chk("lw_s2", {28'd0, state}, 2);
    chk("lw_adr_src_b", {30'd0, alu_src_b}, 2);
    chk("lw_adr_src_a", {31'd0, alu_src_a}, 1);
    tick();
    chk("lw_s3", {28'd0, state}, 3);
    chk("lw_rd_iord", {31'd0, iord}, 1);
    chk("lw_rd_mem_write", {31'd0, mem_write}, 0);
    tick();
    chk("lw_s4", {28'd0, state}, 4);
    chk("lw_wb_reg_write", {31'd0, reg_write}, 1);
    chk("lw_wb_mem_to_reg", {31'd0, mem_to_reg}, 1);
    chk("lw_wb_reg_dst", {31'd0, reg_dst}, 0);
    tick();
    chk("lw_s0", {28'd0, state}, 0);
    chk("lw_retired", retired, 1);

    // sw with 3 wait cycles
    op = 6'b101011;
    tick();
    tick();
    chk("sw_s2", {28'd0, state}, 2);
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        mem_ready = 1'b1;
        #1;
      end
      chk("sw_wait_state", {28'd0, state}, 5);
      chk("sw_wait_mem_write", {31'd0, mem_write}, 1);
      chk("sw_wait_mem_req", {31'd0, mem_req}, 1);
      chk("sw_wait_retired", retired, 1);
      tick();
    end
    chk("sw_s0", {28'd0, state}, 0);
    chk("sw_retired", retired, 2);

    // R-type slt
    op = 6'b000000; funct = 6'b101010;
    tick();
    tick();
    chk("slt_s6", {28'd0, state}, 6);
    chk("slt_alu_control", {29'd0, alu_control}, 3'b111);
    chk("slt_src_b", {30'd0, alu_src_b}, 0);
    tick();
    chk("slt_s7", {28'd0, state}, 7);
    chk("slt_reg_dst", {31'd0, reg_dst}, 1);
    chk("slt_reg_write", {31'd0, reg_write}, 1);
    tick();
    chk("slt_retired", retired, 3);

    // R-type bad funct
    funct = 6'b000111;
    tick();
    tick();
    chk("badf_s6", {28'd0, state}, 6);
    chk("badf_reg_write", {31'd0, reg_write}, 0);
    tick();
    chk("badf_s0", {28'd0, state}, 0);
    chk("badf_illegal", {31'd0, illegal}, 1);
    chk("badf_retired", retired, 3);

    // beq both zero values
    op = 6'b000100;
    tick();
    tick();
    chk("beq_s8", {28'd0, state}, 8);
    zero = 1'b1;
    #1;
    chk("beq_z1_pc_en", {31'd0, pc_en}, 1);
    chk("beq_z1_pc_src", {30'd0, pc_src}, 1);
    zero = 1'b0;
    #1;
    chk("beq_z0_pc_en", {31'd0, pc_en}, 0);
    chk("beq_z0_alu_control", {29'd0, alu_control}, 3'b110);
    tick();
    chk("beq_s0", {28'd0, state}, 0);
    chk("beq_retired", retired, 4);

    // reset during MEMRD wait
    op = 6'b100011;
    tick();
    tick();
    mem_ready = 1'b0;
    tick();
    tick();
    chk("rstw_hold_s3", {28'd0, state}, 3);
    rst = 1'b1;
    #1;
    chk("rstw_mem_req", {31'd0, mem_req}, 0);
    tick();
    rst = 1'b0;
    chk("rstw_s0", {28'd0, state}, 0);
    chk("rstw_retired", retired, 0);
    chk("rstw_illegal", {31'd0, illegal}, 0);

    // jump opcode
    op = 6'b000010; mem_ready = 1'b1;
    tick();
    tick();
`ifdef MULTICYCLE_JUMP_EN
    chk("j_s10", {28'd0, state}, 10);
    chk("j_pc_en", {31'd0, pc_en}, 1);
    chk("j_pc_src", {30'd0, pc_src}, 2);
    tick();
    chk("j_retired", retired, 1);
    chk("j_illegal", {31'd0, illegal}, 0);
`else
    chk("j_s0", {28'd0, state}, 0);
    chk("j_illegal", {31'd0, illegal}, 1);
    chk("j_retired", retired, 0);
`endif

    // addi with retired preloaded to all ones
    mem_ready = 1'b0;
    chk("addi_pre_s0", {28'd0, state}, 0);
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    tick();
    chk("addi_preload", retired, 32'hFFFF_FFFF);
    op = 6'b001000; mem_ready = 1'b1;
    tick();
    tick();
    chk("addi_s9", {28'd0, state}, 9);
    chk("addi_src_b", {30'd0, alu_src_b}, 2);
    tick();
    chk("addi_s7", {28'd0, state}, 7);
    chk("addi_reg_dst", {31'd0, reg_dst}, 0);
    chk("addi_reg_write", {31'd0, reg_write}, 1);
    tick();
    chk("addi_s0", {28'd0, state}, 0);
    chk("addi_wrap", retired, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
